// File: rtl/led_ctrl_pkg.sv
// Shared constants for the LED mode controller: mode encodings, pattern width
// and the small helpers that describe mode sequencing.
package led_ctrl_pkg;

  localparam int LED_W = 6;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_FLASH  = 2'd1,
    MODE_ALL_ON = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_RUN:    return MODE_FLASH;
      MODE_FLASH:  return MODE_ALL_ON;
      MODE_ALL_ON: return MODE_OFF;
      default:     return MODE_RUN;
    endcase
  endfunction

  // Pattern value loaded when a mode is entered (1 = lit).
  function automatic logic [LED_W-1:0] entry_pattern(input mode_e m);
    case (m)
      MODE_ALL_ON: return '1;
      default:     return '0;
    endcase
  endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// Key event bus between a key debouncer (master) and the mode controller (slave).
// press: single-cycle pulse, no backpressure; the consumer must act on it in that cycle.
interface led_mode_ctrl_if;
  logic press;

  modport master (output press);
  modport slave  (input  press);
endinterface

// File: rtl/key_debounce.sv
// One raw active-low key: 2-flop synchronizer, debouncer and press-event pulse.
// Events are only armed after a released level has been seen since reset.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            key_ni,
  led_mode_ctrl_if.master evt
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          valid1_q, valid2_q;
  logic          armed_q, armed_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      armed_q  <= 1'b0;
      level_q  <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_ni;
      sync2_q  <= sync1_q;
      valid1_q <= 1'b1;
      valid2_q <= valid1_q;
      armed_q  <= armed_d;
      level_q  <= level_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  // valid2_q marks that sync2_q holds a real key sample rather than the reset
  // value, so a key held through reset release never arms the press event.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    armed_d = armed_q | (valid2_q & sync2_q);
    if (sync2_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = sync2_q;
        press_d = armed_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign evt.press = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Six-LED controller: key0 cycles RUN/FLASH/ALL_ON/OFF, key1 pauses the
// running or flashing pattern. LEDs are active-low and driven from a register.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned STEP_TICKS  = 10000000,
  parameter int unsigned FLASH_TICKS = 5000000
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             key0,
  input  logic             key1,
  output logic [LED_W-1:0] led_o,
  output logic [1:0]       mode_o,
  output logic             paused_o
);

  localparam int unsigned TICK_MAX = (STEP_TICKS > FLASH_TICKS) ? STEP_TICKS : FLASH_TICKS;
  localparam int unsigned TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX + 1) : 1;
  localparam logic [TW-1:0] STEP_LAST  = TW'(STEP_TICKS - 1);
  localparam logic [TW-1:0] FLASH_LAST = TW'(FLASH_TICKS - 1);

  led_mode_ctrl_if key0_evt ();
  led_mode_ctrl_if key1_evt ();

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key0 (
    .clk_i  (sys_clk),
    .rst_ni (rst_n),
    .key_ni (key0),
    .evt    (key0_evt)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key1 (
    .clk_i  (sys_clk),
    .rst_ni (rst_n),
    .key_ni (key1),
    .evt    (key1_evt)
  );

  mode_e            mode_q, mode_d;
  logic             paused_q, paused_d;
  logic             dir_up_q, dir_up_d;
  logic [LED_W-1:0] pattern_q, pattern_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [TW-1:0]    tick_last;
  logic             step;
  logic             animated;
  logic             press0, press1;

  assign press0 = key0_evt.press;
  assign press1 = key1_evt.press;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_RUN;
      paused_q  <= 1'b0;
      dir_up_q  <= 1'b1;
      pattern_q <= '0;
      led_q     <= '1;
      tick_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      paused_q  <= paused_d;
      dir_up_q  <= dir_up_d;
      pattern_q <= pattern_d;
      led_q     <= led_d;
      tick_q    <= tick_d;
    end
  end

  // A key event owns its cycle: the tick counter does not advance when a
  // mode change or pause toggle is applied.
  always_comb begin
    mode_d    = mode_q;
    paused_d  = paused_q;
    dir_up_d  = dir_up_q;
    pattern_d = pattern_q;
    tick_d    = tick_q;
    step      = 1'b0;
    animated  = (mode_q == MODE_RUN) || (mode_q == MODE_FLASH);
    tick_last = (mode_q == MODE_FLASH) ? FLASH_LAST : STEP_LAST;

    if (press0 && press1) begin
      mode_d    = MODE_RUN;
      pattern_d = '0;
      dir_up_d  = 1'b1;
      paused_d  = 1'b0;
      tick_d    = '0;
    end else if (press0) begin
      mode_d    = next_mode(mode_q);
      pattern_d = entry_pattern(mode_d);
      dir_up_d  = 1'b1;
      paused_d  = 1'b0;
      tick_d    = '0;
    end else if (press1 && animated) begin
      paused_d = ~paused_q;
    end else if (animated && !paused_q) begin
      if (tick_q == tick_last) begin
        tick_d = '0;
        step   = 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end

    if (step) begin
      case (mode_q)
        MODE_RUN: begin
          if (dir_up_q) begin
            if (pattern_q != '1) pattern_d = {pattern_q[LED_W-2:0], 1'b1};
            else                 dir_up_d  = 1'b0;
          end else begin
            if (pattern_q != '0) pattern_d = pattern_q >> 1;
            else                 dir_up_d  = 1'b1;
          end
        end
        MODE_FLASH: pattern_d = ~pattern_q;
        default:    pattern_d = pattern_q;
      endcase
    end

    led_d = ~pattern_d;
  end

  assign led_o    = led_q;
  assign mode_o   = mode_q;
  assign paused_o = paused_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl with short debounce/step/flash periods; a cycle model
// predicts led/mode/paused every cycle, directed tasks check the key scenarios.
module tb_led_mode_ctrl;

  localparam int DB    = 4;
  localparam int STEP  = 3;
  localparam int FLASH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_n = 2'b11;
  logic [5:0] led_o;
  logic [1:0] mode_o;
  logic       paused_o;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  led_mode_ctrl #(
    .DB_CYCLES   (DB),
    .STEP_TICKS  (STEP),
    .FLASH_TICKS (FLASH)
  ) dut (
    .sys_clk  (clk),
    .rst_n    (rst_n),
    .key0     (key_n[0]),
    .key1     (key_n[1]),
    .led_o    (led_o),
    .mode_o   (mode_o),
    .paused_o (paused_o)
  );

  // ---------------- reference model (advances on each active edge) ----------
  logic [1:0]    m_s1, m_s2, m_acc, m_armed, m_press, m_new_press;
  logic [DB-1:0] m_hist [2];
  logic [DB-1:0] m_h;
  int            m_vcnt;
  logic [1:0]    m_mode;
  logic [5:0]    m_pat;
  logic          m_up, m_paused;
  int            m_tick, m_lim;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 2'b11; m_s2 = 2'b11; m_acc = 2'b11; m_armed = 2'b00; m_press = 2'b00;
      m_hist[0] = '1; m_hist[1] = '1; m_vcnt = 0;
      m_mode = 2'd0; m_pat = 6'h00; m_up = 1'b1; m_paused = 1'b0; m_tick = 0;
      exp_q.delete();
    end else begin
      if (m_press[0] && m_press[1]) begin
        m_mode = 2'd0; m_pat = 6'h00; m_up = 1'b1; m_paused = 1'b0; m_tick = 0;
      end else if (m_press[0]) begin
        m_mode = m_mode + 2'd1;
        m_pat = (m_mode == 2'd2) ? 6'h3F : 6'h00;
        m_up = 1'b1; m_paused = 1'b0; m_tick = 0;
      end else if (m_press[1]) begin
        if (m_mode <= 2'd1) m_paused = !m_paused;
      end else if (!m_paused && m_mode <= 2'd1) begin
        m_lim = (m_mode == 2'd1) ? FLASH - 1 : STEP - 1;
        if (m_tick == m_lim) begin
          m_tick = 0;
          if (m_mode == 2'd1) m_pat = ~m_pat;
          else if (m_up) begin
            if (m_pat == 6'h3F) m_up = 1'b0; else m_pat = {m_pat[4:0], 1'b1};
          end else begin
            if (m_pat == 6'h00) m_up = 1'b1; else m_pat = m_pat >> 1;
          end
        end else begin
          m_tick = m_tick + 1;
        end
      end
      // key path: accepted level flips once the last DB synced samples all disagree
      for (int k = 0; k < 2; k++) begin
        m_h = {m_hist[k][DB-2:0], m_s2[k]};
        m_new_press[k] = 1'b0;
        if (m_h == {DB{~m_acc[k]}}) begin
          m_acc[k] = m_s2[k];
          m_new_press[k] = m_armed[k] & ~m_s2[k];
        end
        m_hist[k] = m_h;
        if (m_vcnt >= 2 && m_s2[k]) m_armed[k] = 1'b1;
        m_s2[k] = m_s1[k];
        m_s1[k] = key_n[k];
      end
      m_press = m_new_press;
      if (m_vcnt < 2) m_vcnt = m_vcnt + 1;
      exp_q.push_back({~m_pat, m_mode, m_paused});
    end
  end

  // ---------------- clock/sample helper with scoreboard pop -----------------
  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    if (!rst_n) begin
      checks++;
      if ({led_o, mode_o, paused_o} !== {6'h3F, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL reset_outputs: got led=%h mode=%0d paused=%b, expected led=3f mode=0 paused=0",
                 led_o, mode_o, paused_o);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({led_o, mode_o, paused_o} !== e) begin
        errors++;
        $display("FAIL scoreboard @%0t: got led=%h mode=%0d paused=%b, expected led=%h mode=%0d paused=%b",
                 $time, led_o, mode_o, paused_o, e[8:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic drive_key(input int k, input logic v);
    #1 key_n[k] = v;
  endtask

  task automatic press_key(input int k);
    drive_key(k, 1'b0);
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 10) drive_key(k, 1'b1);
    end
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    #1 rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (led_o !== 6'h3F) begin errors++; $display("FAIL reset_led: got %h expected 3f", led_o); end
    checks++;
    if (mode_o !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode_o); end
    checks++;
    if (paused_o !== 1'b0) begin errors++; $display("FAIL reset_paused: got %b expected 0", paused_o); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_idle_run();
    logic [5:0] seq [14];
    seq = '{6'h3F, 6'h3E, 6'h3C, 6'h38, 6'h30, 6'h20, 6'h00,
            6'h00, 6'h20, 6'h30, 6'h38, 6'h3C, 6'h3E, 6'h3F};
    for (int n = 1; n <= 60; n++) begin
      tick();
      checks++;
      if (led_o !== seq[(n / STEP) % 14]) begin
        errors++;
        $display("FAIL idle_run cycle %0d: got led=%h expected %h", n, led_o, seq[(n / STEP) % 14]);
      end
    end
  endtask

  task automatic test_bounce_then_press();
    int changes;
    logic [1:0] prev_mode;
    logic [5:0] prev_led;
    for (int p = 0; p < 4; p++) begin
      drive_key(0, 1'b0);
      repeat (3) tick();
      drive_key(0, 1'b1);
      repeat (3) tick();
    end
    repeat (10) tick();
    checks++;
    if (mode_o !== 2'd0) begin errors++; $display("FAIL bounce_mode: got %0d expected 0", mode_o); end
    changes = 0;
    prev_mode = mode_o;
    drive_key(0, 1'b0);
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (mode_o !== prev_mode) changes++;
      prev_mode = mode_o;
      if (i == 10) drive_key(0, 1'b1);
    end
    checks++;
    if (changes !== 1 || mode_o !== 2'd1) begin
      errors++;
      $display("FAIL press_once: got changes=%0d mode=%0d expected changes=1 mode=1", changes, mode_o);
    end
    changes = 0;
    prev_led = led_o;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (led_o !== 6'h3F && led_o !== 6'h00) begin
        errors++; $display("FAIL flash_value: got %h expected 3f or 00", led_o);
      end
      if (led_o !== prev_led) changes++;
      prev_led = led_o;
    end
    checks++;
    if (changes !== 4) begin errors++; $display("FAIL flash_rate: got %0d toggles expected 4", changes); end
  endtask

  task automatic test_pause();
    do_reset();
    repeat (3) tick();
    drive_key(1, 1'b0);
    for (int i = 1; i <= 28; i++) begin
      tick();
      if (i >= 8) begin
        checks++;
        if (paused_o !== 1'b1 || led_o !== 6'h38) begin
          errors++;
          $display("FAIL pause_frozen i=%0d: got paused=%b led=%h expected paused=1 led=38", i, paused_o, led_o);
        end
      end
      if (i == 10) drive_key(1, 1'b1);
    end
    drive_key(1, 1'b0);
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 8 || i == 9) begin
        checks++;
        if (paused_o !== 1'b0 || led_o !== 6'h38) begin
          errors++;
          $display("FAIL resume_hold i=%0d: got paused=%b led=%h expected paused=0 led=38", i, paused_o, led_o);
        end
      end
      if (i == 10) begin
        checks++;
        if (led_o !== 6'h30) begin errors++; $display("FAIL resume_tick: got led=%h expected 30", led_o); end
        drive_key(1, 1'b1);
      end
    end
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_mode [4];
    logic [5:0] exp_led  [4];
    exp_mode = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_led  = '{6'h3F, 6'h00, 6'h3F, 6'h3F};
    for (int p = 0; p < 4; p++) begin
      drive_key(0, 1'b0);
      for (int i = 1; i <= 22; i++) begin
        tick();
        if (i == 8) begin
          checks++;
          if (mode_o !== exp_mode[p] || led_o !== exp_led[p] || paused_o !== 1'b0) begin
            errors++;
            $display("FAIL mode_step %0d: got mode=%0d led=%h paused=%b expected mode=%0d led=%h paused=0",
                     p, mode_o, led_o, paused_o, exp_mode[p], exp_led[p]);
          end
        end
        if (i == 11 && p == 3) begin
          checks++;
          if (led_o !== 6'h3E) begin errors++; $display("FAIL run_reentry: got led=%h expected 3e", led_o); end
        end
        if (i == 10) drive_key(0, 1'b1);
      end
      if (p == 1) begin
        drive_key(1, 1'b0);
        for (int i = 1; i <= 22; i++) begin
          tick();
          if (i == 8 || i == 20) begin
            checks++;
            if (paused_o !== 1'b0 || mode_o !== 2'd2) begin
              errors++;
              $display("FAIL all_on_key1: got paused=%b mode=%0d expected paused=0 mode=2", paused_o, mode_o);
            end
          end
          if (i == 10) drive_key(1, 1'b1);
        end
      end
    end
  endtask

  task automatic test_both_keys();
    press_key(0);
    press_key(1);
    checks++;
    if (mode_o !== 2'd1 || paused_o !== 1'b1) begin
      errors++; $display("FAIL flash_paused_setup: got mode=%0d paused=%b expected mode=1 paused=1", mode_o, paused_o);
    end
    #1 key_n = 2'b00;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 8) begin
        checks++;
        if (mode_o !== 2'd0 || paused_o !== 1'b0 || led_o !== 6'h3F) begin
          errors++;
          $display("FAIL both_keys: got mode=%0d paused=%b led=%h expected mode=0 paused=0 led=3f", mode_o, paused_o, led_o);
        end
      end
      if (i == 10) key_n = 2'b11;
    end
  endtask

  task automatic test_reset_mid_debounce();
    press_key(0);
    drive_key(0, 1'b0);
    repeat (4) tick();
    #1 rst_n = 1'b0;
    tick();
    checks++;
    if (led_o !== 6'h3F || mode_o !== 2'd0 || paused_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got led=%h mode=%0d paused=%b expected led=3f mode=0 paused=0", led_o, mode_o, paused_o);
    end
    #1 rst_n = 1'b1;
    repeat (30) tick();
    checks++;
    if (mode_o !== 2'd0) begin errors++; $display("FAIL held_through_reset: got mode=%0d expected 0", mode_o); end
    drive_key(0, 1'b1);
    repeat (12) tick();
    checks++;
    if (mode_o !== 2'd0) begin errors++; $display("FAIL release_no_event: got mode=%0d expected 0", mode_o); end
    press_key(0);
    checks++;
    if (mode_o !== 2'd1) begin errors++; $display("FAIL repress_after_reset: got mode=%0d expected 1", mode_o); end
  endtask

  initial begin
    test_reset();
    test_idle_run();
    test_bounce_then_press();
    test_pause();
    test_mode_cycle();
    test_both_keys();
    test_reset_mid_debounce();
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
